// File: rtl/map_tile_controller.sv
`default_nettype none
// ============================================================================
// Module   : map_tile_controller
// Purpose  : Live, destructible brick map for the current level. Copies the
//            level ROM into a tile array. Serves a renderer read port and a
//            tank collision query port. Clears bricks for two bullet
//            requesters under round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module map_tile_controller #(
   parameter int ROWS  = 30,
   parameter int COLS  = 40,
   parameter int ROW_W = 6,
   parameter int COL_W = 6
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             level_load,
   output logic [ROW_W-1:0] rom_addr,
   input  logic [COLS-1:0]  rom_data,
   output logic             ready,
   output logic             load_done,
   input  logic [ROW_W-1:0] render_row,
   input  logic [COL_W-1:0] render_col,
   output logic             render_tile,
   input  logic             coll_req,
   input  logic [ROW_W-1:0] coll_row,
   input  logic [COL_W-1:0] coll_col,
   output logic             coll_valid,
   output logic             coll_tile,
   input  logic [1:0]       dst_req,
   input  logic [ROW_W-1:0] dst_row0,
   input  logic [ROW_W-1:0] dst_row1,
   input  logic [COL_W-1:0] dst_col0,
   input  logic [COL_W-1:0] dst_col1,
   output logic [1:0]       dst_ack,
   output logic [1:0]       dst_hit
);

   // Row index width actually needed to address the tile array
   localparam int               ROW_IW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [ROW_W-1:0] R_MAX  = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] C_MAX  = COL_W'(COLS - 1);
   localparam logic [COLS-1:0]  ONE    = {{(COLS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
   logic             load_we;

   logic [COLS-1:0]  map_q [ROWS];

   logic             load_done_q;
   logic             render_tile_q, render_tile_d;
   logic             coll_valid_q;
   logic             coll_tile_q, coll_tile_d;
   logic [1:0]       dst_ack_q, dst_hit_q;
   logic             rr_q;

   logic [1:0]       elig;
   logic             grant_v;
   logic             grant_idx;
   logic [ROW_W-1:0] g_row;
   logic [COL_W-1:0] g_col;
   logic             g_in;
   logic             g_old;

   // Coordinates beyond the map edge never touch the array
   function automatic logic in_map(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
      return (r <= R_MAX) && (c <= C_MAX);
   endfunction

   // Column 0 lives in the row word MSB
   function automatic logic tile_bit(input logic [COLS-1:0] w, input logic [COL_W-1:0] c);
      logic [COLS-1:0] s;
      s = w >> (C_MAX - c);
      return s[0];
   endfunction

   assign ready       = (state_q == READY);
   assign load_done   = load_done_q;
   assign render_tile = render_tile_q;
   assign coll_valid  = coll_valid_q;
   assign coll_tile   = coll_tile_q;
   assign dst_ack     = dst_ack_q;
   assign dst_hit     = dst_hit_q;

   // FSM next state: a load pulse restarts loading from row 0 in any state
   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      load_we   = 1'b0;
      rom_addr  = '0;
      case (state_q)
         LOAD: begin
            rom_addr = row_cnt_q;
            load_we  = 1'b1;
            if (row_cnt_q == R_MAX) begin
               state_d   = READY;
               row_cnt_d = '0;
            end else begin
               row_cnt_d = row_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
      if (level_load) begin
         state_d   = LOAD;
         row_cnt_d = '0;
      end
   end

   // FSM state and load row counter
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         row_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
      end
   end

   // Read-port lookups: off-map and not-ready read as empty for the renderer, blocked for tanks
   always_comb begin
      render_tile_d = 1'b0;
      coll_tile_d   = 1'b1;
      if (ready && in_map(render_row, render_col))
         render_tile_d = tile_bit(map_q[render_row[ROW_IW-1:0]], render_col);
      if (ready && in_map(coll_row, coll_col))
         coll_tile_d = tile_bit(map_q[coll_row[ROW_IW-1:0]], coll_col);
   end

   // Destroy arbitration: a port in its ack cycle is not eligible, ties go to rr_q
   always_comb begin
      elig      = dst_req & ~dst_ack_q & {2{ready}};
      grant_v   = |elig;
      grant_idx = (elig == 2'b11) ? rr_q : elig[1];
      g_row     = grant_idx ? dst_row1 : dst_row0;
      g_col     = grant_idx ? dst_col1 : dst_col0;
      g_in      = in_map(g_row, g_col);
      g_old     = 1'b0;
      if (g_in)
         g_old = tile_bit(map_q[g_row[ROW_IW-1:0]], g_col);
   end

   // Tile array: ROM copy while loading, brick clears while ready
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int r = 0; r < ROWS; r++)
            map_q[r] <= '0;
      end else if (load_we) begin
         map_q[row_cnt_q[ROW_IW-1:0]] <= rom_data;
      end else if (grant_v && g_in) begin
         map_q[g_row[ROW_IW-1:0]] <= map_q[g_row[ROW_IW-1:0]] & ~(ONE << (C_MAX - g_col));
      end
   end

   // Registered port responses and round-robin pointer
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         load_done_q   <= 1'b0;
         render_tile_q <= 1'b0;
         coll_valid_q  <= 1'b0;
         coll_tile_q   <= 1'b0;
         dst_ack_q     <= '0;
         dst_hit_q     <= '0;
         rr_q          <= 1'b0;
      end else begin
         load_done_q   <= (state_q == LOAD) && (state_d == READY);
         render_tile_q <= render_tile_d;
         coll_valid_q  <= coll_req;
         coll_tile_q   <= coll_tile_d;
         dst_ack_q     <= '0;
         dst_hit_q     <= '0;
         if (grant_v) begin
            dst_ack_q[grant_idx] <= 1'b1;
            dst_hit_q[grant_idx] <= g_old;
            rr_q                 <= ~grant_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_map_tile_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_tile_controller
// Purpose  : Self-checking bench for map_tile_controller: fixed vectors,
//            hand-written destroy/reload sequences and a randomized phase
//            against a tile-grid reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_tile_controller;

   localparam int ROWS  = 30;
   localparam int COLS  = 40;
   localparam int ROW_W = 6;
   localparam int COL_W = 6;

   logic             Clk = 1'b0;
   logic             Reset_n;
   logic             level_load;
   logic [ROW_W-1:0] rom_addr;
   logic [COLS-1:0]  rom_data;
   logic             ready, load_done;
   logic [ROW_W-1:0] render_row;
   logic [COL_W-1:0] render_col;
   logic             render_tile;
   logic             coll_req;
   logic [ROW_W-1:0] coll_row;
   logic [COL_W-1:0] coll_col;
   logic             coll_valid, coll_tile;
   logic [1:0]       dst_req;
   logic [ROW_W-1:0] dst_row0, dst_row1;
   logic [COL_W-1:0] dst_col0, dst_col1;
   logic [1:0]       dst_ack, dst_hit;

   logic [COLS-1:0]  rom [ROWS];
   bit               model [ROWS][COLS];
   int               n_pass = 0;
   int               n_total = 0;

   always #5 Clk = ~Clk;

   assign rom_data = (int'(rom_addr) < ROWS) ? rom[rom_addr[4:0]] : '0;

   map_tile_controller #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .level_load(level_load),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .ready(ready), .load_done(load_done),
      .render_row(render_row), .render_col(render_col), .render_tile(render_tile),
      .coll_req(coll_req), .coll_row(coll_row), .coll_col(coll_col),
      .coll_valid(coll_valid), .coll_tile(coll_tile),
      .dst_req(dst_req), .dst_row0(dst_row0), .dst_row1(dst_row1),
      .dst_col0(dst_col0), .dst_col1(dst_col1),
      .dst_ack(dst_ack), .dst_hit(dst_hit)
   );

   typedef struct {
      int r;
      int c;
      bit exp_render;
      bit exp_coll;
   } vec_t;

   vec_t vt [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Reference tile grid: tile (r,c) is ROM word bit COLS-1-c
   task automatic model_from_rom();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            model[r][c] = rom[r][COLS-1-c];
   endtask

   function automatic bit model_tile(input int r, input int c);
      if (r < ROWS && c < COLS) return model[r][c];
      return 1'b0;
   endfunction

   function automatic bit model_coll(input int r, input int c);
      if (r < ROWS && c < COLS) return model[r][c];
      return 1'b1;
   endfunction

   task automatic set_dst(input logic [1:0] req, input int r0, input int c0, input int r1, input int c1);
      dst_req  = req;
      dst_row0 = ROW_W'(r0);
      dst_col0 = COL_W'(c0);
      dst_row1 = ROW_W'(r1);
      dst_col1 = COL_W'(c1);
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      tick();
      tick();
      Reset_n = 1'b1;
   endtask

   // Load without detailed per-cycle checks; ends in the first ready cycle
   task automatic quick_load();
      level_load = 1'b1;
      tick();
      level_load = 1'b0;
      for (int k = 0; k < ROWS; k++) tick();
      check("quick_load_ready", ready, 1);
      model_from_rom();
   endtask

   task automatic sweep_render();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            render_row = ROW_W'(r);
            render_col = COL_W'(c);
            tick();
            check($sformatf("sweep_render(%0d,%0d)", r, c), render_tile, model[r][c]);
         end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] t;
      bit          hold [2];
      int          hr [2], hc [2];
      bit          pend_ack [2];
      bit          rr;
      int          g, rr_r, rr_c, cr, cc;
      logic [1:0]  e_ack, e_hit;
      bit          e_render, e_ct, creq;

      // ROM: random content with a few tiles pinned for the directed checks
      for (int r = 0; r < ROWS; r++) begin
         t = {$urandom(), $urandom()};
         rom[r] = t[COLS-1:0];
      end
      rom[2][COLS-1-9]  = 1'b1;
      rom[2][COLS-1-8]  = 1'b0;
      for (int c = 18; c <= 21; c++) rom[27][COLS-1-c] = 1'b1;
      rom[27][COLS-1-17] = 1'b0;
      rom[0][COLS-1-0]   = 1'b0;

      vt[0] = '{2, 9, 1'b1, 1'b1};
      vt[1] = '{2, 8, 1'b0, 1'b0};
      vt[2] = '{27, 18, 1'b1, 1'b1};
      vt[3] = '{27, 19, 1'b1, 1'b1};
      vt[4] = '{27, 20, 1'b1, 1'b1};
      vt[5] = '{27, 21, 1'b1, 1'b1};
      vt[6] = '{27, 17, 1'b0, 1'b0};
      vt[7] = '{30, 0, 1'b0, 1'b1};
      vt[8] = '{0, 0, 1'b0, 1'b0};
      vt[9] = '{5, 40, 1'b0, 1'b1};

      level_load = 1'b0;
      render_row = '0; render_col = '0;
      coll_req = 1'b0; coll_row = '0; coll_col = '0;
      set_dst(2'b00, 0, 0, 0, 0);

      // Reset state
      do_reset();
      check("rst_ready", ready, 0);
      check("rst_load_done", load_done, 0);
      check("rst_render_tile", render_tile, 0);
      check("rst_coll_valid", coll_valid, 0);
      check("rst_coll_tile", coll_tile, 0);
      check("rst_dst_ack", dst_ack, 0);
      check("rst_dst_hit", dst_hit, 0);
      check("rst_rom_addr", rom_addr, 0);

      // Detailed load: rom_addr sweep, tanks blocked during load
      level_load = 1'b1;
      tick();
      level_load = 1'b0;
      coll_req = 1'b1;
      for (int k = 0; k < ROWS; k++) begin
         check($sformatf("load_rom_addr[%0d]", k), rom_addr, k);
         check($sformatf("load_ready[%0d]", k), ready, 0);
         tick();
         check($sformatf("load_coll_valid[%0d]", k), coll_valid, 1);
         check($sformatf("load_coll_tile[%0d]", k), coll_tile, 1);
      end
      check("load_ready_T31", ready, 1);
      check("load_done_T31", load_done, 1);
      check("load_rom_addr_T31", rom_addr, 0);
      coll_req = 1'b0;
      tick();
      check("load_done_T32", load_done, 0);
      check("ready_T32", ready, 1);
      model_from_rom();

      // Fixed render / collision vectors
      for (int i = 0; i < 10; i++) begin
         render_row = ROW_W'(vt[i].r);
         render_col = COL_W'(vt[i].c);
         coll_req   = 1'b1;
         coll_row   = ROW_W'(vt[i].r);
         coll_col   = COL_W'(vt[i].c);
         tick();
         check($sformatf("vec_render(%0d,%0d)", vt[i].r, vt[i].c), render_tile, vt[i].exp_render);
         check($sformatf("vec_coll_valid(%0d,%0d)", vt[i].r, vt[i].c), coll_valid, 1);
         check($sformatf("vec_coll_tile(%0d,%0d)", vt[i].r, vt[i].c), coll_tile, vt[i].exp_coll);
      end
      coll_req = 1'b0;
      tick();
      check("coll_valid_drop", coll_valid, 0);

      // Player destroys (2,9); tile reads empty afterwards
      set_dst(2'b01, 2, 9, 0, 0);
      tick();
      check("d1_ack", dst_ack, 2'b01);
      check("d1_hit", dst_hit, 2'b01);
      set_dst(2'b00, 0, 0, 0, 0);
      coll_req = 1'b1; coll_row = 6'd2; coll_col = 6'd9;
      tick();
      check("d1_ack_pulse", dst_ack, 2'b00);
      check("d1_requery", coll_tile, 0);
      coll_req = 1'b0;

      // Repeat destroy of an empty tile
      set_dst(2'b01, 2, 9, 0, 0);
      tick();
      check("d2_ack", dst_ack, 2'b01);
      check("d2_hit", dst_hit, 2'b00);
      set_dst(2'b00, 0, 0, 0, 0);
      tick();

      // Enemy single grant on an empty tile; pointer now favours the player
      set_dst(2'b10, 0, 0, 0, 0);
      tick();
      check("d3_ack", dst_ack, 2'b10);
      check("d3_hit", dst_hit, 2'b00);
      set_dst(2'b00, 0, 0, 0, 0);
      tick();

      // Dual request on the same brick: player first, enemy finds it gone
      set_dst(2'b11, 27, 18, 27, 18);
      tick();
      check("d4_ack_a", dst_ack, 2'b01);
      check("d4_hit_a", dst_hit, 2'b01);
      set_dst(2'b10, 27, 18, 27, 18);
      tick();
      check("d4_ack_b", dst_ack, 2'b10);
      check("d4_hit_b", dst_hit, 2'b00);
      set_dst(2'b00, 0, 0, 0, 0);
      tick();

      // Player single grant, then dual: enemy first; collision sees pre-write value
      set_dst(2'b01, 27, 19, 0, 0);
      tick();
      check("d5_ack", dst_ack, 2'b01);
      check("d5_hit", dst_hit, 2'b01);
      set_dst(2'b00, 0, 0, 0, 0);
      tick();
      set_dst(2'b11, 27, 20, 27, 20);
      coll_req = 1'b1; coll_row = 6'd27; coll_col = 6'd20;
      tick();
      check("d6_ack_a", dst_ack, 2'b10);
      check("d6_hit_a", dst_hit, 2'b10);
      check("d6_coll_prewrite", coll_tile, 1);
      set_dst(2'b01, 27, 20, 27, 20);
      coll_req = 1'b0;
      tick();
      check("d6_ack_b", dst_ack, 2'b01);
      check("d6_hit_b", dst_hit, 2'b00);
      set_dst(2'b00, 0, 0, 0, 0);
      tick();

      // Off-map destroy: acked, no hit, edge still blocks
      set_dst(2'b01, 5, 40, 0, 0);
      coll_req = 1'b1; coll_row = 6'd5; coll_col = 6'd40;
      tick();
      check("d7_ack", dst_ack, 2'b01);
      check("d7_hit", dst_hit, 2'b00);
      check("d7_coll_edge", coll_tile, 1);
      set_dst(2'b00, 0, 0, 0, 0);
      coll_req = 1'b0;
      tick();

      // Randomized phase from a fresh reset and load
      do_reset();
      quick_load();
      rr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         hold[i] = 1'b0; pend_ack[i] = 1'b0; hr[i] = 0; hc[i] = 0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (hold[i] && pend_ack[i]) begin
               hold[i] = ($urandom_range(2, 0) == 0);
               hr[i] = int'($urandom_range(31, 0));
               hc[i] = int'($urandom_range(43, 0));
            end else if (!hold[i] && $urandom_range(1, 0) == 1) begin
               hold[i] = 1'b1;
               hr[i] = int'($urandom_range(31, 0));
               hc[i] = int'($urandom_range(43, 0));
            end
         end
         set_dst({hold[1], hold[0]}, hr[0], hc[0], hr[1], hc[1]);
         rr_r = int'($urandom_range(31, 0));
         rr_c = int'($urandom_range(47, 0));
         cr   = int'($urandom_range(31, 0));
         cc   = int'($urandom_range(47, 0));
         creq = $urandom_range(1, 0) == 1;
         render_row = ROW_W'(rr_r); render_col = COL_W'(rr_c);
         coll_req = creq; coll_row = ROW_W'(cr); coll_col = COL_W'(cc);

         // Expected responses from the current grid, then apply the destroy
         e_render = model_tile(rr_r, rr_c);
         e_ct     = model_coll(cr, cc);
         g = -1;
         if (hold[0] && !pend_ack[0] && hold[1] && !pend_ack[1]) g = int'(rr);
         else if (hold[0] && !pend_ack[0]) g = 0;
         else if (hold[1] && !pend_ack[1]) g = 1;
         e_ack = 2'b00; e_hit = 2'b00;
         if (g >= 0) begin
            e_ack[g] = 1'b1;
            e_hit[g] = model_tile(hr[g], hc[g]);
            if (hr[g] < ROWS && hc[g] < COLS) model[hr[g]][hc[g]] = 1'b0;
            rr = (g == 0);
         end

         tick();
         check($sformatf("rnd_ack[%0d]", cyc), dst_ack, e_ack);
         check($sformatf("rnd_hit[%0d]", cyc), dst_hit, e_hit);
         check($sformatf("rnd_render[%0d]", cyc), render_tile, e_render);
         check($sformatf("rnd_coll_valid[%0d]", cyc), coll_valid, creq);
         if (creq) check($sformatf("rnd_coll_tile[%0d]", cyc), coll_tile, e_ct);
         pend_ack[0] = e_ack[0];
         pend_ack[1] = e_ack[1];
      end
      set_dst(2'b00, 0, 0, 0, 0);
      coll_req = 1'b0;
      tick();
      tick();

      // Reload interrupted at row 10; enemy request waits through the load
      level_load = 1'b1;
      tick();
      level_load = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check("reload_rom_addr_10", rom_addr, 10);
      check("reload_ready_mid", ready, 0);
      level_load = 1'b1;
      set_dst(2'b10, 0, 0, 27, 19);
      tick();
      level_load = 1'b0;
      check("reload_restart_addr", rom_addr, 0);
      for (int k = 1; k < ROWS; k++) begin
         tick();
         check($sformatf("reload_ready[%0d]", k), ready, 0);
         check($sformatf("reload_no_ack[%0d]", k), dst_ack, 0);
      end
      check("reload_last_addr", rom_addr, ROWS - 1);
      tick();
      check("reload_ready", ready, 1);
      check("reload_done", load_done, 1);
      check("reload_ack_wait", dst_ack, 0);
      tick();
      check("reload_ack", dst_ack, 2'b10);
      check("reload_hit", dst_hit, 2'b10);
      set_dst(2'b00, 0, 0, 0, 0);
      model_from_rom();
      model[27][19] = 1'b0;
      coll_req = 1'b1; coll_row = 6'd2; coll_col = 6'd9;
      tick();
      check("reload_restore_coll(2,9)", coll_tile, 1);
      coll_req = 1'b0;
      sweep_render();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
